// File: rtl/pll_reset_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pll_reset_seq_pkg                                             |
// | Desc     : State encodings and shared constants for the PLL reset        |
// |            sequencer.                                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package pll_reset_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_WAIT   = 2'd0;
    localparam state_t S_HOLD   = 2'd1;
    localparam state_t S_PERIPH = 2'd2;
    localparam state_t S_RUN    = 2'd3;

    localparam int c_sync_depth = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_seq_lock_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pll_reset_seq_lock_filter                                     |
// | Desc     : Synchronises the PLL lock flag and debounces it into a level  |
// |            lock_good and a single-cycle lock_lost pulse.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pll_reset_seq_lock_filter
    import pll_reset_seq_pkg::*;
#(
    parameter int LOCK_FILTER = 4,
    parameter int LOSS_FILTER = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pll_locked,
    output logic o_lock_good,
    output logic o_lock_lost
);

    localparam int c_hw = $clog2(LOCK_FILTER + 1);
    localparam int c_lw = $clog2(LOSS_FILTER + 1);

    localparam logic [c_hw-1:0] c_hi_max = c_hw'(LOCK_FILTER);
    localparam logic [c_hw-1:0] c_hi_one = c_hw'(1);
    localparam logic [c_lw-1:0] c_lo_max = c_lw'(LOSS_FILTER);
    localparam logic [c_lw-1:0] c_lo_one = c_lw'(1);
    localparam logic [c_lw-1:0] c_lo_pre = c_lw'(LOSS_FILTER - 1);

    logic [c_sync_depth-1:0] r_sync;
    logic [c_hw-1:0]         r_hi_cnt;
    logic [c_lw-1:0]         r_lo_cnt;
    logic                    w_ls;

    assign w_ls = r_sync[c_sync_depth-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
        end else begin
            r_sync <= {r_sync[c_sync_depth-2:0], i_pll_locked};

            if (!w_ls)
                r_hi_cnt <= '0;
            else if (r_hi_cnt != c_hi_max)
                r_hi_cnt <= r_hi_cnt + c_hi_one;

            if (w_ls)
                r_lo_cnt <= '0;
            else if (r_lo_cnt != c_lo_max)
                r_lo_cnt <= r_lo_cnt + c_lo_one;
        end
    end

    // lock_lost fires only on the sample that brings the low count up to the
    // threshold; the saturated count keeps it from firing again.
    assign o_lock_good = (r_hi_cnt == c_hi_max);
    assign o_lock_lost = !w_ls && (r_lo_cnt == c_lo_pre);

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pll_reset_seq                                                 |
// | Desc     : Staged reset sequencer behind the board PLL. Releases the     |
// |            peripheral reset, then the CPU reset, after a filtered lock.  |
// |            Define PLL_LOSS_CNT_EN to enable the lock-loss event counter. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGGER     = 16,
    parameter int LOCK_FILTER = 4,
    parameter int LOSS_FILTER = 2
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_rst,
    output logic       rst_periph,
    output logic       rst_cpu,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] loss_cnt
);

    localparam int c_cw = $clog2(max_int(HOLD_CYCLES, STAGGER) + 1);

    localparam logic [c_cw-1:0] c_hold_last = c_cw'(HOLD_CYCLES - 1);
    localparam logic [c_cw-1:0] c_stag_last = c_cw'(STAGGER - 1);
    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);

    logic            w_lock_good;
    logic            w_lock_lost;
    state_t          r_state;
    state_t          w_state_next;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_next;
    logic            r_rst_periph;
    logic            r_rst_cpu;
    logic            r_ready;
    logic            w_rst_periph;
    logic            w_rst_cpu;
    logic            w_ready;

    pll_reset_seq_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER),
        .LOSS_FILTER (LOSS_FILTER)
    ) u_lock_filter (
        .clk          (clkin),
        .rst          (rst),
        .i_pll_locked (pll_locked),
        .o_lock_good  (w_lock_good),
        .o_lock_lost  (w_lock_lost)
    );

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state      <= S_WAIT;
            r_cnt        <= '0;
            r_rst_periph <= 1'b1;
            r_rst_cpu    <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_rst_periph <= w_rst_periph;
            r_rst_cpu    <= w_rst_cpu;
            r_ready      <= w_ready;
        end
    end

    // Aborts are checked ahead of the per-state progression so lock loss
    // beats a software request and both override normal sequencing.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if ((r_state != S_WAIT) && w_lock_lost) begin
            w_state_next = S_WAIT;
            w_cnt_next   = '0;
        end else if ((r_state != S_WAIT) && sw_rst && w_lock_good) begin
            w_state_next = S_HOLD;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    w_cnt_next = '0;
                    if (w_lock_good)
                        w_state_next = S_HOLD;
                end
                S_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        w_state_next = S_PERIPH;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_cnt_one;
                    end
                end
                S_PERIPH: begin
                    if (r_cnt == c_stag_last) begin
                        w_state_next = S_RUN;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_cnt_one;
                    end
                end
                S_RUN: begin
                    w_cnt_next = '0;
                end
                default: begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they register on the same edge as it.
    always_comb begin
        w_rst_periph = 1'b1;
        w_rst_cpu    = 1'b1;
        w_ready      = 1'b0;
        case (w_state_next)
            S_PERIPH: w_rst_periph = 1'b0;
            S_RUN: begin
                w_rst_periph = 1'b0;
                w_rst_cpu    = 1'b0;
                w_ready      = 1'b1;
            end
            default: ;
        endcase
    end

    assign rst_periph = r_rst_periph;
    assign rst_cpu    = r_rst_cpu;
    assign ready      = r_ready;
    assign state      = r_state;

`ifdef PLL_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clkin) begin
        if (rst)
            r_loss_cnt <= 8'd0;
        else if (w_lock_lost && (r_state != S_WAIT) && (r_loss_cnt != 8'hFF))
            r_loss_cnt <= r_loss_cnt + 8'd1;
    end

    assign loss_cnt = r_loss_cnt;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pll_reset_seq                                              |
// | Desc     : Scoreboard bench for pll_reset_seq (HOLD=8, STAGGER=4).       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pll_reset_seq;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sw_rst = 1'b0;
    logic       rst_periph;
    logic       rst_cpu;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss_cnt;

    pll_reset_seq #(
        .HOLD_CYCLES (8),
        .STAGGER     (4),
        .LOCK_FILTER (4),
        .LOSS_FILTER (2)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .pll_locked (pll_locked),
        .sw_rst     (sw_rst),
        .rst_periph (rst_periph),
        .rst_cpu    (rst_cpu),
        .ready      (ready),
        .state      (state),
        .loss_cnt   (loss_cnt)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        int          cyc;
        string       tag;
        logic [12:0] exp;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  n_loss = 0;

    always @(posedge clkin) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_lc();
`ifdef PLL_LOSS_CNT_EN
        return (n_loss > 255) ? 8'd255 : 8'(n_loss);
`else
        return 8'd0;
`endif
    endfunction

    // Packed view: {loss_cnt, rst_periph, rst_cpu, ready, state}
    function automatic logic [12:0] ev(input logic rp, input logic rc,
                                       input logic rdy, input logic [1:0] st);
        return {exp_lc(), rp, rc, rdy, st};
    endfunction

    task automatic push(input int c, input string tag, input logic [12:0] e);
        sb_t s;
        s.cyc = c;
        s.tag = tag;
        s.exp = e;
        sb.push_back(s);
    endtask

    always @(posedge clkin) begin
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_t s;
            s = sb.pop_front();
            check_eq(s.tag, {19'd0, loss_cnt, rst_periph, rst_cpu, ready, state}, {19'd0, s.exp});
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clkin);
            n++;
        end
        if (sb.size() > 0) begin
            check_eq("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // c is the edge count when pll_locked was driven high; the next edge samples it.
    task automatic lock_seq(input int c, input string tag);
        int e0 = c + 1;
        push(e0 + 5,  {tag, "_pre_hold"},  ev(1, 1, 0, 2'd0));
        push(e0 + 6,  {tag, "_hold"},      ev(1, 1, 0, 2'd1));
        push(e0 + 13, {tag, "_pre_periph"}, ev(1, 1, 0, 2'd1));
        push(e0 + 14, {tag, "_periph"},    ev(0, 1, 0, 2'd2));
        push(e0 + 17, {tag, "_pre_run"},   ev(0, 1, 0, 2'd2));
        push(e0 + 18, {tag, "_run"},       ev(0, 0, 1, 2'd3));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c;

        // Power-up: reset for 3 edges, then 50 edges unlocked; sw_rst in S_WAIT is ignored.
        for (int i = 1; i <= 53; i++)
            push(i, (i <= 3) ? "reset_state" : "unlocked", ev(1, 1, 0, 2'd0));
        repeat (3) @(negedge clkin);
        rst = 1'b0;
        repeat (17) @(negedge clkin);
        sw_rst = 1'b1;
        @(negedge clkin);
        sw_rst = 1'b0;
        drain();

        // First lock.
        @(negedge clkin);
        pll_locked = 1'b1;
        lock_seq(cyc, "lock");
        drain();

        // One-cycle glitch while running.
        @(negedge clkin);
        c = cyc;
        for (int i = 1; i <= 8; i++)
            push(c + i, "glitch", ev(0, 0, 1, 2'd3));
        pll_locked = 1'b0;
        @(negedge clkin);
        pll_locked = 1'b1;
        drain();

        // Five-cycle loss then relock.
        @(negedge clkin);
        c = cyc;
        n_loss++;
        pll_locked = 1'b0;
        push(c + 6, "loss", ev(1, 1, 0, 2'd0));
        repeat (5) @(negedge clkin);
        pll_locked = 1'b1;
        lock_seq(cyc, "relock");
        drain();

        // Single-cycle software reset.
        @(negedge clkin);
        c = cyc;
        sw_rst = 1'b1;
        push(c + 1,  "swr_hold",       ev(1, 1, 0, 2'd1));
        push(c + 8,  "swr_pre_periph", ev(1, 1, 0, 2'd1));
        push(c + 9,  "swr_periph",     ev(0, 1, 0, 2'd2));
        push(c + 12, "swr_pre_run",    ev(0, 1, 0, 2'd2));
        push(c + 13, "swr_run",        ev(0, 0, 1, 2'd3));
        @(negedge clkin);
        sw_rst = 1'b0;
        drain();

        // Software reset held for 5 edges: hold counter restarts after release.
        @(negedge clkin);
        c = cyc;
        sw_rst = 1'b1;
        for (int i = 1; i <= 5; i++)
            push(c + i, "swr_held", ev(1, 1, 0, 2'd1));
        push(c + 12, "swr_rel_pre_periph", ev(1, 1, 0, 2'd1));
        push(c + 13, "swr_rel_periph",     ev(0, 1, 0, 2'd2));
        push(c + 17, "swr_rel_run",        ev(0, 0, 1, 2'd3));
        repeat (5) @(negedge clkin);
        sw_rst = 1'b0;
        drain();

        // Synchronous reset mid-run clears everything, including loss_cnt.
        @(negedge clkin);
        c = cyc;
        rst = 1'b1;
        n_loss = 0;
        push(c + 1, "rst_run", ev(1, 1, 0, 2'd0));
        @(negedge clkin);
        rst = 1'b0;
        lock_seq(cyc, "rst_relock");
        drain();

        // 300 loss/relock rounds, each reaching S_HOLD before the loss.
        for (int i = 0; i < 300; i++) begin
            @(negedge clkin);
            pll_locked = 1'b0;
            repeat (6) @(negedge clkin);
            pll_locked = 1'b1;
            repeat (8) @(negedge clkin);
            n_loss++;
        end
        @(negedge clkin);
        pll_locked = 1'b0;
        n_loss++;
        repeat (6) @(negedge clkin);
        push(cyc + 1, "saturate", ev(1, 1, 0, 2'd0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Reset sequencer directly downstream of the board PLL; consumes the asynchronous PLL lock flag and generates staged synchronous resets for the design.
- Runs on one PLL output clock (system clock, typically the 25 MHz output).
- Filters lock glitches and holds resets for a programmable time after lock. Releases the peripheral reset (VGA, memory controllers) before the CPU reset.
- Re-enters reset on lock loss or a software reset request.

Parameters:
- HOLD_CYCLES, 1024: cycles both resets stay asserted after filtered lock; must be at least 1.
- STAGGER, 16: cycles between rst_periph release and rst_cpu release; must be at least 1.
- LOCK_FILTER, 4: consecutive synchronised high samples required to declare lock good.
- LOSS_FILTER, 2: consecutive synchronised low samples required to declare lock lost.

Ports:
- clkin, input, 1: system clock from the PLL.
- rst, input, 1: synchronous active-high reset. Sequencer returns to S_WAIT.
- pll_locked, input, 1: PLL lock flag; asynchronous to clkin.
- sw_rst, input, 1: synchronous software reset request; level or pulse.
- rst_periph, output, 1: active-high peripheral reset.
- rst_cpu, output, 1: active-high CPU reset.
- ready, output, 1: high only in S_RUN.
- state, output, 2: current state code, for debug and LEDs.
- loss_cnt, output, 8: lock-loss event count (see Optional Feature).

Behaviour:
- Interface: one clock, clkin. rst is synchronous and active-high. All outputs are registered.
- Reset values: rst_periph=1, rst_cpu=1, ready=0, state=S_WAIT (2'd0), loss_cnt=0, all counters 0.
- Synchroniser: two flops on pll_locked produce l_s. No other logic samples pll_locked.
- Lock filter:
  - Saturating counter of consecutive l_s=1 samples; lock_good=1 when it reaches LOCK_FILTER.
  - Separate counter of consecutive l_s=0 samples; lock_lost pulses when it reaches LOSS_FILTER.
  - Each counter clears when its sample value flips.
- States: S_WAIT=0, S_HOLD=1, S_PERIPH=2, S_RUN=3.
  - S_WAIT: both resets asserted. On lock_good, go to S_HOLD with the cycle counter at 0.
  - S_HOLD: both resets asserted; counter increments. At HOLD_CYCLES-1, go to S_PERIPH and deassert rst_periph on the same edge.
  - S_PERIPH: rst_periph=0, rst_cpu=1; counter counts STAGGER cycles. Then go to S_RUN, with rst_cpu=0 and ready=1 on the same edge.
  - S_RUN: hold until an abort event.
- Latency: rst_periph falls exactly 2+LOCK_FILTER+HOLD_CYCLES clkin cycles after the first edge that samples pll_locked=1. rst_cpu and ready change STAGGER cycles after that.
- Abort, from any state except S_WAIT:
  - lock_lost: go to S_WAIT.
  - sw_rst=1 with lock good: go to S_HOLD with counter 0.
  - In both cases rst_periph=1, rst_cpu=1 and ready=0 on the next edge.
- Abort priority: rst > lock_lost > sw_rst.
- sw_rst held high keeps the block in S_HOLD with counter 0. The sequence restarts when sw_rst falls.
- sw_rst in S_WAIT has no effect.
- A lock glitch shorter than LOSS_FILTER samples does not affect outputs.
- While the PLL is unlocked, clkin may be unstable. The design relies only on rst returning the sequencer to S_WAIT, never on clkin quality.
- Counter width is $clog2 of max(HOLD_CYCLES, STAGGER)+1 bits; the compare uses the full width, with no truncation.

Optional Feature:
- Macro: PLL_LOSS_CNT_EN.
- Defined:
  - loss_cnt is an 8-bit saturating counter (stops at 255).
  - It increments once per lock_lost event that occurs outside S_WAIT.
  - It clears only on rst.
- Undefined: loss_cnt is tied to 8'd0 and its counter logic is absent.
- The port list is identical in both builds.

Decomposition:
- Shared package: state encodings S_WAIT, S_HOLD, S_PERIPH, S_RUN as a 2-bit typedef; constant for the synchroniser depth (2).
- One natural sub-module, lock_filter: synchroniser plus the two filter counters, producing lock_good and lock_lost.
- The sequencer FSM stays in pll_reset_seq.

Test Plan (HOLD_CYCLES=8, STAGGER=4, LOCK_FILTER=4, LOSS_FILTER=2):
- Power-up: rst high 3 cycles, then low with pll_locked=0 for 50 cycles -> rst_periph=1, rst_cpu=1, ready=0, state=0 throughout.
- Lock: pll_locked rises at cycle 0 -> rst_periph falls at cycle 14; rst_cpu falls and ready rises at cycle 18; state reads 1, 2, 3 in sequence.
- Glitch: in S_RUN, pll_locked low for 1 cycle -> no output change, loss_cnt=0.
- Loss: in S_RUN, pll_locked low for 5 cycles then high again ->
  - all resets asserted and state=0 within 2+2+1 cycles of the fall;
  - loss_cnt=1 when PLL_LOSS_CNT_EN is defined;
  - the full sequence repeats with the same 14/18-cycle spacing from the relock.
- Software reset: sw_rst pulsed for 1 cycle in S_RUN -> resets asserted next edge, state=1; rst_periph falls 8 cycles later and rst_cpu 4 cycles after that.
- Saturation: 300 loss/relock cycles with the macro defined -> loss_cnt=255; with the macro undefined, loss_cnt=0.
